// File: rtl/regfile_bypass_sb_if.sv
// Decode/writeback-facing bus of the register file: read ports, write port,
// pending-set strobe and the sticky protocol-error flag.
interface regfile_bypass_sb_if #(
    parameter int W  = 16,
    parameter int N  = 8,
    parameter int AW = 3
);
    logic [AW-1:0] read1RegSel;
    logic [AW-1:0] read2RegSel;
    logic [W-1:0]  read1Data;
    logic [W-1:0]  read2Data;
    logic [AW-1:0] writeRegSel;
    logic [W-1:0]  writeData;
    logic          writeEn;
    logic [AW-1:0] pendSel;
    logic          pendEn;
    logic          read1Pending;
    logic          read2Pending;
    logic          err;

    // Pipeline side: decode/writeback drive selects and strobes.
    modport master (
        output read1RegSel, read2RegSel, writeRegSel, writeData, writeEn,
               pendSel, pendEn,
        input  read1Data, read2Data, read1Pending, read2Pending, err
    );

    modport slave (
        input  read1RegSel, read2RegSel, writeRegSel, writeData, writeEn,
               pendSel, pendEn,
        output read1Data, read2Data, read1Pending, read2Pending, err
    );
endinterface

// File: rtl/regfile_bypass_sb.sv
// N x W register file with two combinational read ports, one write port,
// write-to-read bypass and per-register pending (scoreboard) bits.
module regfile_bypass_sb #(
    parameter int W  = 16,
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic               clk,
    input  logic               rst,
    regfile_bypass_sb_if.slave bus
);
    logic [W-1:0] regs_q [N];
    logic [W-1:0] regs_d [N];
    logic [N-1:0] pend_q;
    logic [N-1:0] pend_d;
    logic         err_q;
    logic         err_d;

    logic byp1;
    logic byp2;
    logic pend_hits_write;
    logic waw_err;
    logic orphan_write_err;

    assign byp1 = bus.writeEn && (bus.writeRegSel == bus.read1RegSel);
    assign byp2 = bus.writeEn && (bus.writeRegSel == bus.read2RegSel);
    assign pend_hits_write = bus.pendEn && bus.writeEn &&
                             (bus.pendSel == bus.writeRegSel);

    assign bus.read1Data    = byp1 ? bus.writeData : regs_q[bus.read1RegSel];
    assign bus.read2Data    = byp2 ? bus.writeData : regs_q[bus.read2RegSel];
    // A retiring write hides the pending bit; a same-cycle pend does not show yet.
    assign bus.read1Pending = pend_q[bus.read1RegSel] && !byp1;
    assign bus.read2Pending = pend_q[bus.read2RegSel] && !byp2;
    assign bus.err          = err_q;

    assign waw_err          = bus.pendEn && pend_q[bus.pendSel] && !pend_hits_write;
    assign orphan_write_err = bus.writeEn && !pend_q[bus.writeRegSel] && !pend_hits_write;

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        err_d  = err_q || waw_err || orphan_write_err;
        if (bus.writeEn) begin
            regs_d[bus.writeRegSel] = bus.writeData;
        end
        for (int i = 0; i < N; i++) begin
            // Set has priority: a new producer issued as the old result retires.
            if (bus.pendEn && (bus.pendSel == AW'(i))) begin
                pend_d[i] = 1'b1;
            end else if (bus.writeEn && (bus.writeRegSel == AW'(i))) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
- Parametrised multi-register successor to the single write-enabled register: an N-entry, W-bit register file.
- Two combinational read ports and one synchronous write port.
- Write-to-read bypass in the same cycle.
- Per-register pending (scoreboard) bits used by decode to detect outstanding producers.
- Sits between decode and writeback in the pipeline; decode reads operands and pending status, writeback writes results.

Parameters:
- W, 16, data width of each register.
- N, 8, number of registers; must be a power of two, ≥2.
- AW, 3, select width; must equal log2(N).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- read1RegSel  input  AW  read port 1 register select.
- read2RegSel  input  AW  read port 2 register select.
- read1Data  output  W  read port 1 data.
- read2Data  output  W  read port 2 data.
- writeRegSel  input  AW  write port register select.
- writeData  input  W  write port data.
- writeEn  input  1  write strobe; also clears the target's pending bit.
- pendSel  input  AW  register to mark pending.
- pendEn  input  1  set pending strobe.
- read1Pending  output  1  pending status of read1RegSel.
- read2Pending  output  1  pending status of read2RegSel.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset (async, immediate on rst high, held while high):
  - all N registers = 0; all pending bits = 0; err = 0.
  - Outputs therefore read 0 for data/pending unless bypass is active.
  - Reset mid-operation discards any same-cycle write or pend.
- Storage: each register updates on rising clk only when writeEn=1 and writeRegSel selects it; otherwise it holds.
  - No register is hardwired; R0 is an ordinary register.
- Reads: combinational, zero latency.
  - readXData = reg[readXRegSel], except bypass.
  - Bypass: if writeEn=1 and writeRegSel==readXRegSel, readXData = writeData in the same cycle. Both ports may bypass simultaneously.
- Pending bits: N flops. At rising clk, for each register i:
  - set if pendEn=1 and pendSel==i;
  - else clear if writeEn=1 and writeRegSel==i;
  - else hold.
  - pendEn and writeEn to the same register in the same cycle: set wins. A new producer was issued as the old result retires.
- readXPending (combinational):
  - = pending[readXRegSel], forced to 0 when a same-cycle bypassing write targets readXRegSel.
  - Reports the pre-edge value otherwise; a same-cycle pendEn does not affect it.
- err (registered, sticky):
  - Set at rising clk when pendEn=1 targets a register whose pending bit is 1 and that register is not being written the same cycle (WAW without retirement).
  - Also set when writeEn=1 targets a register whose pending bit is 0 and pendEn is not targeting it (write with no producer).
  - Cleared only by rst. err does not block any other update.
- Arithmetic/width: selects are exactly AW bits, so no out-of-range index exists; no wrap logic is required.

Test Plan:
1. Reset check: assert rst asynchronously mid-cycle after writing reg3=0x1234 and pend reg5 -> read1Data for sel 3 = 0x0000, read1Pending for sel 5 = 0, err = 0, all immediately without a clock edge.
2. Basic write/read, N=8, W=16: write reg2=0xBEEF, then reg7=0x0001 on successive edges -> next cycle read1(sel2)=0xBEEF, read2(sel7)=0x0001; unwritten reg4 reads 0x0000.
3. Bypass: reg6 holds 0x1111; in one cycle writeEn=1, writeRegSel=6, writeData=0x2222, read1Sel=read2Sel=6 -> both read 0x2222 combinationally that cycle; 0x2222 persists after the edge.
4. Scoreboard:
   - pendEn sel1 -> after edge read1Pending(sel1)=1.
   - Write reg1=0x00AA -> same cycle read1Pending=0 and read1Data=0x00AA; after edge pending=0, err=0.
5. Set-wins collision: reg4 pending; same cycle writeEn reg4=0x5555 and pendEn sel4 -> after edge pending[4]=1, reg4=0x5555, err=0.
6. Errors:
   - pendEn sel3 twice without an intervening write -> err=1 after the second edge.
   - Separately after reset: write reg0 with pending[0]=0 -> err=1; err stays 1 across further legal traffic until rst.
   - Parametrisation rerun with W=32, N=16, AW=4 of scenarios 2–4 using sel 15 and data 0xDEADBEEF.
